// File: rtl/aes_seq_pkg.sv
// Shared types and widths for the AES block sequencer.
// Contents: sequencer state enum, word/block widths, word-counter width.
package aes_seq_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BLOCK_W         = 128;
  localparam int unsigned WCNT_W          = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [2:0] {
    COLLECT,
    CORE_RST,
    START,
    WAIT_DONE,
    DRAIN
  } state_t;

endpackage

// File: rtl/aes_word_serializer.sv
// 128-to-32 bit output serializer with valid/ready handshake.
// Ports: clk, rst_n; load/load_data capture a block (MSW first out);
//        m_data/m_valid/m_ready stream interface; last_c pulses
//        combinationally on the final word handshake.
module aes_word_serializer
  import aes_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  output logic [WORD_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               last_c
);

  logic [BLOCK_W-1:0] obuf_q, obuf_d;
  logic [WCNT_W-1:0]  cnt_q, cnt_d;
  logic               valid_q, valid_d;

  // Next-state: load a new block or shift out one word per handshake
  always_comb begin
    obuf_d  = obuf_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_c  = valid_q && m_ready && (cnt_q == WCNT_W'(WORDS_PER_BLOCK - 1));
    if (load) begin
      obuf_d  = load_data;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && m_ready) begin
      obuf_d = {obuf_q[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
      cnt_d  = cnt_q + WCNT_W'(1);
      if (last_c) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obuf_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      obuf_q  <= obuf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign m_data  = obuf_q[BLOCK_W-1 -: WORD_W];
  assign m_valid = valid_q;

endmodule

// File: rtl/aes_block_sequencer.sv
// Feeds AES_Core one block at a time: packs four 32-bit input words into a
// plaintext block, resets and starts the core, waits for done (with a
// timeout) and streams the ciphertext back out as four 32-bit words.
// Ports: s_* input word stream; key_in/key_we key load (idle only);
//        core_* AES_Core interface; m_* output word stream;
//        busy, sticky timeout_err, wrapping blk_count status.
module aes_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [BLOCK_W-1:0] key_in,
  input  logic               key_we,
  output logic               core_rst,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_plaintext,
  output logic [BLOCK_W-1:0] core_key,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_ciphertext,
  output logic [WORD_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy,
  output logic               timeout_err,
  output logic [15:0]        blk_count
);

  localparam int unsigned RCNT_W = 4;
  localparam int unsigned TO_W   = 16;
  localparam int unsigned BCNT_W = 16;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [BLOCK_W-1:0] pt_q, pt_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
  logic [TO_W-1:0]    tocnt_q, tocnt_d;
  logic               core_rst_q, core_rst_d;
  logic               core_start_q, core_start_d;
  logic               s_ready_q, s_ready_d;
  logic               busy_q, busy_d;
  logic               timeout_err_q, timeout_err_d;
  logic [BCNT_W-1:0]  blk_count_q, blk_count_d;
  logic               ser_load;
  logic               ser_last_c;

  // Next-state and registered-output logic; outputs are decoded from the
  // next state so they are valid in the same cycle the state is entered.
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    pt_d          = pt_q;
    key_d         = key_q;
    rcnt_d        = rcnt_q;
    tocnt_d       = tocnt_q;
    timeout_err_d = timeout_err_q;
    blk_count_d   = blk_count_q;
    core_rst_d    = 1'b0;
    core_start_d  = 1'b0;
    s_ready_d     = 1'b0;
    busy_d        = 1'b0;
    ser_load      = 1'b0;

    case (state_q)
      COLLECT: begin
        // Key may only change between blocks
        if (key_we && (wcnt_q == '0)) key_d = key_in;
        if (s_valid && s_ready_q) begin
          pt_d   = {pt_q[BLOCK_W-WORD_W-1:0], s_data};
          wcnt_d = wcnt_q + WCNT_W'(1);
          if (wcnt_q == WCNT_W'(WORDS_PER_BLOCK - 1)) begin
            rcnt_d  = '0;
            state_d = CORE_RST;
          end
        end
      end
      CORE_RST: begin
        if (rcnt_q == RCNT_W'(RST_CYCLES - 1)) state_d = START;
        else                                   rcnt_d  = rcnt_q + RCNT_W'(1);
      end
      START: begin
        tocnt_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (core_done) begin
          ser_load = 1'b1;
          state_d  = DRAIN;
        end else if (tocnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the block; one reset cycle unlocks the core
          timeout_err_d = 1'b1;
          core_rst_d    = 1'b1;
          state_d       = COLLECT;
        end else begin
          tocnt_d = tocnt_q + TO_W'(1);
        end
      end
      DRAIN: begin
        if (ser_last_c) begin
          blk_count_d = blk_count_q + BCNT_W'(1);
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (state_d == CORE_RST) core_rst_d = 1'b1;
    core_start_d = (state_d == START);
    s_ready_d    = (state_d == COLLECT);
    busy_d       = (state_d != COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      wcnt_q        <= '0;
      pt_q          <= '0;
      key_q         <= '0;
      rcnt_q        <= '0;
      tocnt_q       <= '0;
      core_rst_q    <= 1'b1;
      core_start_q  <= 1'b0;
      s_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      blk_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      pt_q          <= pt_d;
      key_q         <= key_d;
      rcnt_q        <= rcnt_d;
      tocnt_q       <= tocnt_d;
      core_rst_q    <= core_rst_d;
      core_start_q  <= core_start_d;
      s_ready_q     <= s_ready_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      blk_count_q   <= blk_count_d;
    end
  end

  aes_word_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (core_ciphertext),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .last_c    (ser_last_c)
  );

  assign s_ready        = s_ready_q;
  assign core_rst       = core_rst_q;
  assign core_start     = core_start_q;
  assign core_plaintext = pt_q;
  assign core_key       = key_q;
  assign busy           = busy_q;
  assign timeout_err    = timeout_err_q;
  assign blk_count      = blk_count_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Scoreboard bench for aes_block_sequencer with a behavioural AES_Core stub.
module tb_aes_block_sequencer;

  localparam int RST_C = 2;
  localparam int TO_C  = 16;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk, rst_n;
  logic [31:0]  s_data;
  logic         s_valid, s_ready;
  logic [127:0] key_in;
  logic         key_we;
  logic         core_rst, core_start, core_done;
  logic [127:0] core_plaintext, core_key, core_ciphertext;
  logic [31:0]  m_data;
  logic         m_valid, m_ready;
  logic         busy, timeout_err;
  logic [15:0]  blk_count;

  aes_block_sequencer #(.RST_CYCLES(RST_C), .TIMEOUT_CYCLES(TO_C)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .key_in(key_in), .key_we(key_we), .core_rst(core_rst), .core_start(core_start),
    .core_plaintext(core_plaintext), .core_key(core_key), .core_done(core_done),
    .core_ciphertext(core_ciphertext), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .timeout_err(timeout_err), .blk_count(blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  exp_q[$];
  int           cmp_cnt = 0;
  int           err_cnt = 0;
  logic [127:0] key_model = '0;
  int           exp_blk = 0;
  bit           stub_hang = 0;
  int           stub_lat = 3;
  bit           bp_force = 0;
  bit           rand_ready = 0;

  // What the core computes: the real FIPS-197 answer for its vector,
  // an arbitrary keyed mix for anything else.
  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] k);
    if (pt == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return pt ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    cmp_cnt++;
    if (act !== want) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // AES_Core stub: done is sticky until core_rst
  initial begin
    int lat;
    bit run;
    logic [127:0] pt, k;
    core_done = 1'b0; core_ciphertext = '0; run = 0; lat = 0; pt = '0; k = '0;
    forever begin
      @(posedge clk); #1;
      if (core_rst) begin
        core_done = 1'b0; run = 0;
      end else if (core_start) begin
        run = 1; lat = stub_lat; pt = core_plaintext; k = core_key;
      end else if (run && !stub_hang) begin
        if (lat <= 1) begin
          core_done = 1'b1; core_ciphertext = core_fn(pt, k); run = 0;
        end else lat--;
      end
    end
  end

  // Downstream ready driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_force)        m_ready = 1'b0;
      else if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
      else                 m_ready = 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on every output handshake
  initial begin
    logic [31:0] held, w;
    bit hold;
    hold = 0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 0;
      else begin
        if (hold) begin
          chk("m_valid_hold", m_valid, 1);
          chk("m_data_hold", m_data, held);
        end
        hold = m_valid && !m_ready;
        held = m_data;
        if (m_valid) chk("s_ready_during_drain", s_ready, 0);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL unexpected_output: got %h want no output (t=%0t)", m_data, $time);
          end else begin
            w = exp_q.pop_front();
            chk("m_data", m_data, w);
          end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n;
    s_data = w; s_valid = 1'b1; n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 500) begin
        cmp_cnt++; err_cnt++;
        $display("FAIL s_ready_timeout: got s_ready=0 want 1 within 500 cycles");
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // Issue one block; the expected ciphertext words go on the scoreboard first
  task automatic send_block(input logic [127:0] blk, input int gap, input bit expect_out);
    logic [127:0] ct;
    if (expect_out) begin
      ct = core_fn(blk, key_model);
      for (int i = 0; i < 4; i++) exp_q.push_back(ct[127-32*i -: 32]);
      exp_blk++;
    end
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin @(posedge clk); #1; end
      send_word(blk[127-32*i -: 32]);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in = k; key_we = 1'b1;
    @(posedge clk); #1;
    key_we = 1'b0;
    key_model = k;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !m_valid) break;
      n++;
      if (n > 2000) begin
        cmp_cnt++; err_cnt++;
        $display("FAIL idle_timeout: got busy=%0d pending=%0d want idle", busy, exp_q.size());
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (core_start) break;
      n++;
      if (n > 200) begin
        cmp_cnt++; err_cnt++;
        $display("FAIL start_timeout: got core_start=0 want 1 within 200 cycles");
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int start_at, rst_hi, st_hi, cnt, n;
    logic [127:0] blk;
    rst_n = 1'b1; s_data = '0; s_valid = 1'b0; key_in = '0; key_we = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_blk_count", blk_count, 0);
    chk("rst_core_key", core_key, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_core_rst", core_rst, 0);
    chk("post_rst_s_ready", s_ready, 1);

    // 1: FIPS-197 vector at full rate
    load_key(FIPS_KEY);
    send_block(FIPS_PT, 0, 1);
    wait_idle();
    chk("fips_blk_count", blk_count, 1);
    chk("fips_core_key", core_key, FIPS_KEY);

    // 2: toggling s_valid; reset / start timing
    send_block(FIPS_PT, 1, 1);
    start_at = 0; rst_hi = 0; st_hi = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (core_rst) rst_hi++;
      if (core_start) begin
        st_hi++;
        if (start_at == 0) start_at = i;
      end else if (start_at != 0) break;
    end
    chk("start_latency", start_at, RST_C + 1);
    chk("core_rst_width", rst_hi, RST_C);
    chk("core_start_width", st_hi, 1);
    wait_idle();
    chk("t2_blk_count", blk_count, exp_blk);

    // 3: backpressure at the start of DRAIN
    bp_force = 1;
    send_block(FIPS_PT, 0, 1);
    n = 0;
    while (!m_valid && n < 200) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_data", m_data, 32'h69c4e0d8);
      chk("bp_s_ready", s_ready, 0);
    end
    bp_force = 0;
    wait_idle();
    chk("t3_blk_count", blk_count, exp_blk);

    // 4: timeout with a hung core
    stub_hang = 1;
    send_block({$urandom, $urandom, $urandom, $urandom}, 0, 0);
    wait_start();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (timeout_err) break;
    end
    chk("timeout_cycles", cnt, TO_C + 1);
    chk("timeout_core_rst", core_rst, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_s_ready", s_ready, 1);
    chk("timeout_blk_count", blk_count, exp_blk);
    @(negedge clk);
    chk("timeout_core_rst_release", core_rst, 0);
    stub_hang = 0;
    @(posedge clk); #1;
    send_block({$urandom, $urandom, $urandom, $urandom}, 0, 1);
    wait_idle();
    chk("timeout_sticky", timeout_err, 1);
    chk("t4_blk_count", blk_count, exp_blk);

    // 5: reset during WAIT_DONE, then key_we during DRAIN
    stub_lat = 12;
    send_block({$urandom, $urandom, $urandom, $urandom}, 0, 1);
    wait_start();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete(); exp_blk = 0; key_model = '0;
    chk("midrst_core_rst", core_rst, 1);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_timeout_err", timeout_err, 0);
    chk("midrst_blk_count", blk_count, 0);
    chk("midrst_core_key", core_key, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_s_ready", s_ready, 1);
    stub_lat = 3;
    load_key({$urandom, $urandom, $urandom, $urandom});
    bp_force = 1;
    send_block({$urandom, $urandom, $urandom, $urandom}, 0, 1);
    n = 0;
    while (!m_valid && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    key_in = ~key_model; key_we = 1'b1;
    @(posedge clk); #1;
    key_we = 1'b0;
    chk("key_protect", core_key, key_model);
    bp_force = 0;
    wait_idle();
    send_block({$urandom, $urandom, $urandom, $urandom}, 0, 1);
    wait_idle();
    chk("key_after_drain", core_key, key_model);

    // 6: back-to-back blocks, random downstream ready
    rand_ready = 1;
    send_block({$urandom, $urandom, $urandom, $urandom}, 0, 1);
    send_block({$urandom, $urandom, $urandom, $urandom}, 0, 1);
    wait_idle();
    chk("b2b_blk_count", blk_count, exp_blk);

    // Random traffic
    for (int b = 0; b < 6; b++) begin
      stub_lat = $urandom_range(1, 8);
      blk = {$urandom, $urandom, $urandom, $urandom};
      send_block(blk, $urandom_range(0, 2), 1);
    end
    wait_idle();
    chk("final_blk_count", blk_count, exp_blk);
    chk("final_timeout_err", timeout_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/aes_block_sequencer.md
Name: aes_block_sequencer

Overview:
- Host-side stage that sits directly in front of AES_Core and feeds it.
- Packs a 32-bit input word stream into 128-bit plaintext blocks, pulses the core's reset, starts it, and waits for done.
- Captures the ciphertext and streams it back out as 32-bit words.
- Required because the core locks in FINISH after each block and needs a reset before the next one.

Parameters:
- RST_CYCLES, 2, number of cycles core_rst is held high before each block (legal range 1..15).
- TIMEOUT_CYCLES, 4096, cycles to wait for core_done before aborting the block (legal range 1..65535).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low
- s_data  in  32  plaintext word; first word is plaintext[127:96]
- s_valid  in  1  s_data valid
- s_ready  out  1  sequencer accepts a word
- key_in  in  128  cipher key
- key_we  in  1  latch key_in into key register
- core_rst  out  1  active-high reset to AES_Core
- core_start  out  1  start pulse to AES_Core
- core_plaintext  out  128  packed plaintext block
- core_key  out  128  key register contents
- core_done  in  1  AES_Core done (sticky until core reset)
- core_ciphertext  in  128  AES_Core result
- m_data  out  32  ciphertext word; first word is ciphertext[127:96]
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts a word
- busy  out  1  high in any state except COLLECT
- timeout_err  out  1  sticky; set when a block times out
- blk_count  out  16  number of completed blocks, wraps

Behaviour:
Reset values (rst_n low, asynchronous):
- state = COLLECT; core_rst = 1.
- core_start, s_ready, m_valid, busy, timeout_err, blk_count = 0.
- Word counter = 0; all data registers = 0.
- First clock edge after reset release: core_rst = 0 and s_ready = 1.

COLLECT:
- s_ready = 1.
- On s_valid & s_ready, shift the word into the plaintext buffer, first word landing in [127:96], and increment the 2-bit word counter.
- On the 4th accepted word: counter wraps to 0, go to CORE_RST.

CORE_RST:
- core_rst = 1 for exactly RST_CYCLES cycles, then go to START.

START:
- core_start = 1 for exactly one cycle; core_rst = 0.
- Clear the timeout counter, then go to WAIT_DONE.

WAIT_DONE:
- core_start = 0.
- core_done is sampled only in this state.
- core_done = 1: latch core_ciphertext into the output buffer and go to DRAIN.
- Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES: set timeout_err, discard the block, drive core_rst = 1 for one cycle, and return to COLLECT. blk_count is not incremented.

DRAIN:
- m_valid = 1; m_data = output buffer [127:96].
- On m_valid & m_ready, shift the buffer left by 32 bits.
- After the 4th handshake: increment blk_count (mod 2^16) and go to COLLECT.
- m_data is held stable while m_valid & !m_ready.

Fixed rules:
- core_plaintext and core_key are driven directly from registers and stay stable from CORE_RST through WAIT_DONE.
- key_we is honoured only in COLLECT with word counter = 0; it is ignored at any other time, so the key cannot change mid-block.
- s_ready = 0 in every state except COLLECT; words are never dropped.
- Latency from 4th input word accepted to core_start high = RST_CYCLES + 1 cycles.
- timeout_err is cleared only by rst_n.
- rst_n asserted mid-block: abort immediately and apply all reset values above. The partial block is lost, and core_rst = 1 holds the core in reset.

Decomposition:
- Package aes_seq_pkg holds:
  - state_t enum: COLLECT, CORE_RST, START, WAIT_DONE, DRAIN.
  - WORDS_PER_BLOCK = 4.
  - WORD_W = 32.
  - BLOCK_W = 128.
- One natural sub-module: aes_word_serializer (128-to-32 shift register with valid/ready), used for DRAIN.
- Input packing stays inline.

Test Plan:
1. FIPS-197 vector.
   - Stimulus: key 000102030405060708090a0b0c0d0e0f; words 00112233, 44556677, 8899aabb, ccddeeff; m_ready = 1.
   - Response: m_data sequence 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; blk_count = 1.
2. Handshake and reset timing.
   - Stimulus: same block sent with s_valid toggling every other cycle.
   - Response: identical output; core_rst is high for exactly 2 cycles; core_start is high for exactly 1 cycle, 3 cycles after the 4th word is accepted.
3. Backpressure.
   - Stimulus: m_ready held low for 10 cycles during DRAIN.
   - Response: m_valid = 1 and m_data = 69c4e0d8 stable throughout; s_ready = 0 until the 4th output handshake.
4. Timeout.
   - Stimulus: core_done stubbed to 0, TIMEOUT_CYCLES = 16.
   - Response: timeout_err = 1 after 16 WAIT_DONE cycles; returns to COLLECT; blk_count unchanged; no m_valid.
5. Mid-block reset and key protection.
   - Stimulus: rst_n pulsed low in the middle of WAIT_DONE; key_we asserted during DRAIN.
   - Response: the reset gives all reset values immediately (core_rst = 1, m_valid = 0); the key register is unchanged by the key_we in DRAIN.
6. Back-to-back blocks.
   - Stimulus: two blocks sent back to back.
   - Response: both ciphertexts are correct and in order; blk_count = 2.
